// File: rtl/serv_dmem_resp.sv
// serv_dmem_resp: word-wide data memory slave for a bit-serial CPU, with an
// optional fixed number of wait states before the single-cycle ack.
//
// Ports:
//   i_clk     clock; all state updates on its rising edge
//   i_rst_n   synchronous active-low reset
//   i_wb_cyc  request valid, held by the initiator until ack
//   i_wb_we   1 = write, 0 = read
//   i_wb_adr  byte address; bits [1:0] ignored
//   i_wb_dat  write data
//   i_wb_sel  byte-lane enables for writes
//   o_wb_rdt  read data, valid in the ack cycle, held otherwise
//   o_wb_ack  single-cycle transfer completion
//   o_busy    high while a transfer is waiting or acking
module serv_dmem_resp #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 0,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          capture;

    // Request captured in IDLE, used when the access completes after wait states
    logic [AW-1:0] idx_q;
    logic          oor_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;

    logic [31:0]   rdt_q;
    logic [31:0]   mem [DEPTH];

    logic          in_oor;
    logic [AW-1:0] acc_idx;
    logic          acc_oor;
    logic          acc_we;
    logic [3:0]    acc_sel;
    logic [31:0]   acc_dat;
    logic          enter_ack;

    logic          unused_adr;
    assign unused_adr = ^i_wb_adr[1:0];

    assign in_oor = |i_wb_adr[31:AW+2];

    // With no wait states the access completes on the sampling edge itself, so
    // the live inputs are used; otherwise the captured copy is used.
    always_comb begin
        if (state_q == StIdle) begin
            acc_idx = i_wb_adr[AW+1:2];
            acc_oor = in_oor;
            acc_we  = i_wb_we;
            acc_sel = i_wb_sel;
            acc_dat = i_wb_dat;
        end else begin
            acc_idx = idx_q;
            acc_oor = oor_q;
            acc_we  = we_q;
            acc_sel = sel_q;
            acc_dat = dat_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_wb_cyc) begin
                    capture = 1'b1;
                    if (WAIT == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            StWait: begin
                if (!i_wb_cyc) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Reset gates the completing edge, dropping any pending write or read
    assign enter_ack = i_rst_n && (state_d == StAck) && (state_q != StAck);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_ack && !acc_we) begin
                rdt_q <= acc_oor ? 32'h0 : mem[acc_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (capture) begin
            idx_q <= i_wb_adr[AW+1:2];
            oor_q <= in_oor;
            we_q  <= i_wb_we;
            sel_q <= i_wb_sel;
            dat_q <= i_wb_dat;
        end
    end

    // Memory has no reset so it maps onto a byte-enabled synchronous RAM
    always_ff @(posedge i_clk) begin
        if (enter_ack && acc_we && !acc_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
                end
            end
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = (state_q == StAck);
    assign o_busy   = (state_q == StWait) || (state_q == StAck);

endmodule

// File: tb/tb_serv_dmem_resp.sv
// Bench for serv_dmem_resp: three instances (WAIT = 0, 3, 5) driven by
// directed scenarios and random traffic, checked against a byte-level model.
module tb_serv_dmem_resp;

    localparam int NI = 3;
    localparam int WAITS [NI] = '{0, 3, 5};

    logic        clk;
    logic        rst_n  [NI];
    logic        cyc    [NI];
    logic        we_s   [NI];
    logic [31:0] adr_s  [NI];
    logic [31:0] dat_s  [NI];
    logic [3:0]  sel_s  [NI];
    logic [31:0] rdt    [NI];
    logic        ack    [NI];
    logic        busy   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bytes written so far (kn marks known bytes), last read value
    logic [31:0] mdl      [NI][256];
    logic [3:0]  kn       [NI][256];
    logic [31:0] last_rdt [NI];
    logic [31:0] last_m   [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serv_dmem_resp #(.DEPTH(256), .WAIT(0)) u_w0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_wb_cyc(cyc[0]), .i_wb_we(we_s[0]),
        .i_wb_adr(adr_s[0]), .i_wb_dat(dat_s[0]), .i_wb_sel(sel_s[0]),
        .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_busy(busy[0])
    );
    serv_dmem_resp #(.DEPTH(256), .WAIT(3)) u_w3 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_wb_cyc(cyc[1]), .i_wb_we(we_s[1]),
        .i_wb_adr(adr_s[1]), .i_wb_dat(dat_s[1]), .i_wb_sel(sel_s[1]),
        .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_busy(busy[1])
    );
    serv_dmem_resp #(.DEPTH(256), .WAIT(5)) u_w5 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_wb_cyc(cyc[2]), .i_wb_we(we_s[2]),
        .i_wb_adr(adr_s[2]), .i_wb_dat(dat_s[2]), .i_wb_sel(sel_s[2]),
        .o_wb_rdt(rdt[2]), .o_wb_ack(ack[2]), .o_busy(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble(input int k);
        we_s[k]  = 1'($urandom);
        adr_s[k] = $urandom;
        dat_s[k] = $urandom;
        sel_s[k] = 4'($urandom);
    endtask

    // One complete transfer; checks latency, busy, ack width and read data.
    task automatic xfer(input int k, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
        int          lat;
        bit          got;
        logic        oor;
        logic [7:0]  idx;
        logic [31:0] exp_r, m;
        oor = |adr[31:10];
        idx = adr[9:2];
        if (we) begin
            exp_r = last_rdt[k];
            m     = last_m[k];
        end else if (oor) begin
            exp_r = 32'h0;
            m     = 32'hFFFF_FFFF;
        end else begin
            exp_r = mdl[k][idx];
            for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{kn[k][idx][b]}};
        end
        @(negedge clk);
        cyc[k] = 1'b1; we_s[k] = we; adr_s[k] = adr; dat_s[k] = dat; sel_s[k] = sel;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            check("busy_in_xfer", 32'(busy[k]), 32'd1);
            if (ack[k]) got = 1;
            else scramble(k);  // ignored after sampling
        end
        check("ack_latency", 32'(lat), 32'(WAITS[k] + 1));
        check(we ? "rdt_hold_write" : "read_data", rdt[k] & m, exp_r & m);
        cyc[k] = 1'b0;
        scramble(k);
        @(posedge clk); #1;
        check("ack_width", 32'(ack[k]), 32'd0);
        check("busy_after", 32'(busy[k]), 32'd0);
        if (!we) begin
            last_rdt[k] = exp_r;
            last_m[k]   = m;
        end else if (!oor) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    mdl[k][idx][8*b +: 8] = dat[8*b +: 8];
                    kn[k][idx][b] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0; cyc[k] = 1'b0; we_s[k] = 1'b0;
            adr_s[k] = '0; dat_s[k] = '0; sel_s[k] = '0;
            last_rdt[k] = 32'h0; last_m[k] = 32'hFFFF_FFFF;
            for (int w = 0; w < 256; w++) begin
                mdl[k][w] = '0;
                kn[k][w]  = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("reset_ack", 32'(ack[k]), 32'd0);
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_rdt", rdt[k], 32'h0);
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

        // No wait states: basic write/read
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("deadbeef", rdt[0], 32'hDEADBEEF);

        // Byte lanes
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'b0101);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h1);
        check("byte_lanes", rdt[0], 32'hAA22CC44);

        // sel = 0 write is acked and changes nothing
        xfer(0, 1'b1, 32'h20, 32'h55555555, 4'h0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF);
        check("sel_zero", rdt[0], 32'hAA22CC44);

        // Out of range
        xfer(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF);
        xfer(0, 1'b0, 32'h400, 32'h0, 4'hF);
        check("oor_read", rdt[0], 32'h0);
        xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF);
        check("oor_write", rdt[0], 32'h5A5A5A5A);

        // Three wait states
        xfer(1, 1'b1, 32'h40, 32'hC0FFEE00, 4'hF);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF);
        check("wait3_read", rdt[1], 32'hC0FFEE00);

        // Abort during wait
        xfer(2, 1'b1, 32'h30, 32'h12345678, 4'hF);
        @(negedge clk);
        cyc[2] = 1'b1; we_s[2] = 1'b1; adr_s[2] = 32'h30; dat_s[2] = 32'hFFFFFFFF; sel_s[2] = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_ack_early", 32'(ack[2]), 32'd0);
        end
        cyc[2] = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_no_ack", 32'(ack[2]), 32'd0);
        end
        check("abort_rdt", rdt[2], last_rdt[2]);
        xfer(2, 1'b0, 32'h30, 32'h0, 4'hF);
        check("abort_old_data", rdt[2], 32'h12345678);

        // Reset in the middle of a waited write
        @(negedge clk);
        cyc[1] = 1'b1; we_s[1] = 1'b1; adr_s[1] = 32'h40; dat_s[1] = 32'hFFFFFFFF; sel_s[1] = 4'hF;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        check("rst_ack", 32'(ack[1]), 32'd0);
        check("rst_busy", 32'(busy[1]), 32'd0);
        check("rst_rdt", rdt[1], 32'h0);
        last_rdt[1] = 32'h0;
        last_m[1]   = 32'hFFFF_FFFF;
        rst_n[1] = 1'b1;
        cyc[1]   = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("rst_no_ack", 32'(ack[1]), 32'd0);
        end
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF);
        check("rst_word_kept", rdt[1], 32'hC0FFEE00);

        // Random traffic on every instance
        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 40; t++) begin
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
                else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                xfer(k, 1'($urandom), a, $urandom, 4'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
